// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Reset sequencer and lock supervisor for the system PLL. Runs on the PLL
// reference clock so it keeps working while the PLL output is dead. Pulses the
// PLL reset and waits for lock, retrying a bounded number of times before it
// latches a fault. It holds the system reset until lock has been stable for a
// programmable time, and re-sequences the PLL whenever lock is lost in RUN.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] relock_cnt
);

    // One timer serves every timed state, so it must hold the longest interval.
    localparam int unsigned T_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned T_MAX   = (T_MAX_A > STABLE_CYCLES) ? T_MAX_A : STABLE_CYCLES;
    localparam int unsigned TW      = $clog2(T_MAX + 1);
    localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0]    RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]    LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_LAST  = RW'(MAX_RETRIES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             locked_meta_q;
    logic             locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;

    // Next state, retry bookkeeping and relock counting.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        relock_cnt_d = relock_cnt_q;
        case (state_q)
            S_PLL_RST: begin
                // locked is deliberately ignored here: the full pulse always completes.
                if (timer_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is tested first so it wins over a timeout on the same edge.
                if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (timer_q == LOCK_LAST) begin
                    retry_d = retry_q + 1'b1;
                    if (retry_q == RETRY_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!locked_s_q) begin
                    state_d = S_PLL_RST;
                    if (relock_cnt_q != CNT_MAX) begin
                        relock_cnt_d = relock_cnt_q + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase
    end

    // Shared timer: restarts on every state change, idle outside the timed states.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q) begin
            if (state_q == S_PLL_RST || state_q == S_WAIT_LOCK || state_q == S_STABLE) begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = fault_q | (state_d == S_FAULT);
    end

    // All state, the lock synchronizer and the registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_PLL_RST;
            timer_q       <= '0;
            retry_q       <= '0;
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
            relock_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
            relock_cnt_q  <= relock_cnt_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Edges are counted from rst release; inputs change 1 ns after a rising edge
// and outputs are sampled at that same point.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] relock_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned hi_cnt;
    logic [1:0]  exp_cnt;

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault),
        .relock_cnt(relock_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_relock"}, 32'(relock_cnt), 32'd0);
    endtask

    initial begin
        // Reset state while rst is held
        tick(3);
        chk_reset_vals("rst_hold");

        // 1: never locks -> two 4/20 attempts, then FAULT
        rst = 1'b0;
        tick(3);  chk("t1_e3_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);  chk("t1_e4_pll_rst", 32'(pll_rst), 32'd0);
        tick(19); chk("t1_e23_pll_rst", 32'(pll_rst), 32'd0);
        tick(1);  chk("t1_e24_pll_rst", 32'(pll_rst), 32'd1);
        tick(3);  chk("t1_e27_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);  chk("t1_e28_pll_rst", 32'(pll_rst), 32'd0);
        tick(19); chk("t1_e47_fault", 32'(fault), 32'd0);
        tick(1);
        chk("t1_e48_fault", 32'(fault), 32'd1);
        chk("t1_e48_pll_rst", 32'(pll_rst), 32'd0);
        chk("t1_e48_sys_rst", 32'(sys_rst), 32'd1);
        locked = 1'b1;
        tick(30);
        chk("t1_fault_sticky", 32'(fault), 32'd1);
        chk("t1_fault_pll_rst", 32'(pll_rst), 32'd0);
        chk("t1_fault_sys_rst", 32'(sys_rst), 32'd1);
        chk("t1_fault_ready", 32'(ready), 32'd0);

        // 6b: rst in FAULT is asynchronous
        locked = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_fault_rst");
        tick(2);

        // 2: lock arrives 5 cycles into WAIT_LOCK, E = edge 10, release at edge 20
        rst = 1'b0;
        tick(4);  chk("t2_e4_pll_rst", 32'(pll_rst), 32'd0);
        tick(5);  locked = 1'b1;
        tick(10);
        chk("t2_e19_sys_rst", 32'(sys_rst), 32'd1);
        chk("t2_e19_ready", 32'(ready), 32'd0);
        tick(1);
        chk("t2_e20_sys_rst", 32'(sys_rst), 32'd0);
        chk("t2_e20_ready", 32'(ready), 32'd1);
        chk("t2_e20_relock", 32'(relock_cnt), 32'd0);

        // 4: loss in RUN, L = edge 24, sys_rst rises at edge 26
        tick(3);  locked = 1'b0;
        tick(2);
        chk("t4_l1_sys_rst", 32'(sys_rst), 32'd0);
        chk("t4_l1_ready", 32'(ready), 32'd1);
        tick(1);
        chk("t4_l2_sys_rst", 32'(sys_rst), 32'd1);
        chk("t4_l2_ready", 32'(ready), 32'd0);
        chk("t4_l2_pll_rst", 32'(pll_rst), 32'd1);
        chk("t4_l2_relock", 32'(relock_cnt), 32'd1);
        tick(3);  chk("t4_e29_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);  chk("t4_e30_pll_rst", 32'(pll_rst), 32'd0);

        // 3: relock (E = 31), drop for 3 samples mid-STABLE, re-rise E' = 38, RUN at 48
        locked = 1'b1;
        hi_cnt = 0;
        for (int e = 31; e <= 48; e++) begin
            tick(1);
            if (pll_rst) hi_cnt++;
            if (e == 34) locked = 1'b0;
            if (e == 37) locked = 1'b1;
            if (e == 47) chk("t3_e47_sys_rst", 32'(sys_rst), 32'd1);
        end
        chk("t3_no_pll_pulse", hi_cnt, 32'd0);
        chk("t3_e48_sys_rst", 32'(sys_rst), 32'd0);
        chk("t3_e48_ready", 32'(ready), 32'd1);

        // 5: four more losses -> relock_cnt 2,3,3,3; locked re-rises during PLL_RST
        for (int k = 0; k < 4; k++) begin
            exp_cnt = (k == 0) ? 2'd2 : 2'd3;
            locked = 1'b0;
            tick(3);
            chk("t5_relock", 32'(relock_cnt), 32'(exp_cnt));
            chk("t5_sys_rst", 32'(sys_rst), 32'd1);
            locked = 1'b1;
            tick(3);  chk("t5_pulse_end_hi", 32'(pll_rst), 32'd1);
            tick(1);  chk("t5_pulse_end_lo", 32'(pll_rst), 32'd0);
            tick(8);  chk("t5_pre_run_sys_rst", 32'(sys_rst), 32'd1);
            tick(1);  chk("t5_run_ready", 32'(ready), 32'd1);
        end

        // 6a: rst while in STABLE clears relock_cnt asynchronously
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(7);
        chk("t6_stable_sys_rst", 32'(sys_rst), 32'd1);
        chk("t6_stable_relock", 32'(relock_cnt), 32'd3);
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_stable_rst");
        tick(2);

        // Lock and timeout on the same edge (edge 24): lock wins
        locked = 1'b0;
        rst = 1'b0;
        tick(21); locked = 1'b1;
        tick(3);
        chk("tie_e24_pll_rst", 32'(pll_rst), 32'd0);
        chk("tie_e24_fault", 32'(fault), 32'd0);
        tick(7);  chk("tie_e31_sys_rst", 32'(sys_rst), 32'd1);
        tick(1);  chk("tie_e32_ready", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
